// File: rtl/multicycle_sequencer_if.sv
// Handshake and control bundle between the multicycle sequencer and its datapath/memories.
// The master side is the sequencer; the slave side is the datapath or a testbench.
interface multicycle_sequencer_if #(
  parameter int INSTRUCTION_SIZE = 32
);
  logic                        start;
  logic                        stop;
  logic [INSTRUCTION_SIZE-1:0] instruction;
  logic                        im_req;
  logic                        im_ack;
  logic                        dm_req;
  logic                        dm_ack;
  logic                        ir_load;
  logic                        pc_write_en;
  logic                        rf_write_en;
  logic                        dm_write_en;
  logic [2:0]                  alu_operation;
  logic                        mux_1_sel;
  logic                        mux_2_sel;
  logic [2:0]                  state;
  logic                        illegal;
  logic [15:0]                 instr_count;

  modport master (
    input  start, stop, instruction, im_ack, dm_ack,
    output im_req, dm_req, ir_load, pc_write_en, rf_write_en, dm_write_en,
           alu_operation, mux_1_sel, mux_2_sel, state, illegal, instr_count
  );

  modport slave (
    output start, stop, instruction, im_ack, dm_ack,
    input  im_req, dm_req, ir_load, pc_write_en, rf_write_en, dm_write_en,
           alu_operation, mux_1_sel, mux_2_sel, state, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for a tiny RV64 subset (ld, sd, add, sub): fetch, decode,
// execute, memory, writeback, with a sticky halt on any other instruction.
module multicycle_sequencer #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.master bus
);

  if (INSTRUCTION_SIZE < 32 || WORDSIZE < 1) begin : g_bad_params
    $error("multicycle_sequencer: INSTRUCTION_SIZE must be >= 32 and WORDSIZE >= 1");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    FETCH     = 3'b001,
    DECODE    = 3'b010,
    EXECUTE   = 3'b011,
    MEMORY    = 3'b100,
    WRITEBACK = 3'b101,
    HALT      = 3'b110,
    BAD_CODE  = 3'b111
  } state_t;

  state_t                      state_reg, state_next;
  logic [INSTRUCTION_SIZE-1:0] ir_reg;
  logic                        illegal_reg;
  logic [15:0]                 instr_count_reg;

  logic       im_req, dm_req, ir_load, pc_write_en, rf_write_en, dm_write_en;
  logic [2:0] alu_operation;
  logic       mux_1_sel, mux_2_sel;
  logic       set_illegal, retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       is_ld, is_sd, is_add, is_sub, is_mem, is_legal;
  logic       unused_ir_fields;

  assign opcode = ir_reg[6:0];
  assign rd     = ir_reg[11:7];
  assign funct3 = ir_reg[14:12];
  assign funct7 = ir_reg[31:25];
  assign unused_ir_fields = ^ir_reg[24:15];

  assign is_ld    = (opcode == 7'b0000011);
  assign is_sd    = (opcode == 7'b0100011);
  assign is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_mem   = is_ld || is_sd;
  assign is_legal = is_mem || is_add || is_sub;

  always_comb begin
    state_next    = state_reg;
    im_req        = 1'b0;
    dm_req        = 1'b0;
    ir_load       = 1'b0;
    pc_write_en   = 1'b0;
    rf_write_en   = 1'b0;
    dm_write_en   = 1'b0;
    alu_operation = 3'b000;
    mux_1_sel     = 1'b0;
    mux_2_sel     = 1'b0;
    set_illegal   = 1'b0;
    retire        = 1'b0;

    // ALU controls are pure functions of IR, so they hold steady until retire.
    if (state_reg == EXECUTE || state_reg == MEMORY || state_reg == WRITEBACK) begin
      alu_operation = is_sub ? 3'b001 : 3'b000;
      mux_1_sel     = is_mem;
    end

    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = FETCH;
      end
      FETCH: begin
        im_req = 1'b1;
        if (bus.im_ack) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (is_legal) begin
          state_next = EXECUTE;
        end else begin
          set_illegal = 1'b1;
          state_next  = HALT;
        end
      end
      EXECUTE: begin
        state_next = is_mem ? MEMORY : WRITEBACK;
      end
      MEMORY: begin
        dm_req      = 1'b1;
        dm_write_en = is_sd;
        if (bus.dm_ack) begin
          if (is_sd) retire = 1'b1;
          else       state_next = WRITEBACK;
        end
      end
      WRITEBACK: begin
        rf_write_en = (rd != 5'd0);
        mux_2_sel   = is_ld;
        retire      = 1'b1;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (retire) begin
      pc_write_en = 1'b1;
      state_next  = bus.stop ? IDLE : FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      ir_reg          <= '0;
      illegal_reg     <= 1'b0;
      instr_count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (ir_load)     ir_reg          <= bus.instruction;
      if (set_illegal) illegal_reg     <= 1'b1;
      if (retire)      instr_count_reg <= instr_count_reg + 16'd1;
    end
  end

  assign bus.im_req        = im_req;
  assign bus.dm_req        = dm_req;
  assign bus.ir_load       = ir_load;
  assign bus.pc_write_en   = pc_write_en;
  assign bus.rf_write_en   = rf_write_en;
  assign bus.dm_write_en   = dm_write_en;
  assign bus.alu_operation = alu_operation;
  assign bus.mux_1_sel     = mux_1_sel;
  assign bus.mux_2_sel     = mux_2_sel;
  assign bus.state         = state_reg;
  assign bus.illegal       = illegal_reg;
  assign bus.instr_count   = instr_count_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed vector table, randomized
// instruction stream against a phase-count reference model, and reset/halt/wrap corners.
module tb_multicycle_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3;
  localparam logic [2:0] S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_HALT = 3'd6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;

  multicycle_sequencer_if #(.INSTRUCTION_SIZE(32)) bus ();

  multicycle_sequencer #(.WORDSIZE(64), .INSTRUCTION_SIZE(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          im_wait;
    int          dm_wait;
    logic        stop;
    int          cycles;
    logic [2:0]  alu;
    logic        mux1;
    logic        mux2;
    int          rf;
    int          wb;
    int          dm_cycles;
    int          dm_we_cycles;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: instruction latency is the sum of its phases, each ack wait stretching one phase.
  function automatic vec_t model(input logic [31:0] instr, input int imw, input int dmw, input logic stp);
    vec_t v;
    bit ld, sd, rtype, add, sub;
    ld    = (instr[6:0] == 7'b0000011);
    sd    = (instr[6:0] == 7'b0100011);
    rtype = (instr[6:0] == 7'b0110011) && (instr[14:12] == 3'b000);
    add   = rtype && (instr[31:25] == 7'b0000000);
    sub   = rtype && (instr[31:25] == 7'b0100000);
    v.instr        = instr;
    v.im_wait      = imw;
    v.dm_wait      = dmw;
    v.stop         = stp;
    v.cycles       = (imw + 1) + 1 + 1 + ((ld || sd) ? dmw + 1 : 0) + (sd ? 0 : 1);
    v.alu          = sub ? 3'b001 : 3'b000;
    v.mux1         = ld || sd;
    v.mux2         = ld;
    v.rf           = ((ld || add || sub) && instr[11:7] != 5'd0) ? 1 : 0;
    v.wb           = sd ? 0 : 1;
    v.dm_cycles    = (ld || sd) ? dmw + 1 : 0;
    v.dm_we_cycles = sd ? dmw + 1 : 0;
    return v;
  endfunction

  task automatic begin_instr(input string tag);
    if (bus.state == S_IDLE) begin
      bus.im_ack = 1'b0;
      bus.dm_ack = 1'b0;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
    end
    check({tag, "_fetch_entry"}, {29'd0, bus.state}, {29'd0, S_FETCH});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0, imn = 0, dmn = 0, imq = 0, dmq = 0, dwe = 0;
    int irl = 0, pcw = 0, rfw = 0, m2 = 0, wbc = 0, ctrl_bad = 0;
    bit done = 0;
    bit in_ex;
    begin_instr(tag);
    bus.stop = v.stop;
    while (!done && cyc < 100) begin
      bus.instruction = bus.im_req ? v.instr : $urandom();
      bus.im_ack = bus.im_req ? (imn == v.im_wait) : 1'($urandom_range(0, 1));
      bus.dm_ack = bus.dm_req ? (dmn == v.dm_wait) : 1'($urandom_range(0, 1));
      if (bus.im_req) imn++;
      if (bus.dm_req) dmn++;
      #1;
      cyc++;
      imq += int'(bus.im_req);
      dmq += int'(bus.dm_req);
      dwe += int'(bus.dm_write_en);
      irl += int'(bus.ir_load);
      pcw += int'(bus.pc_write_en);
      rfw += int'(bus.rf_write_en);
      m2  += int'(bus.mux_2_sel);
      wbc += int'(bus.state == S_WRITEBACK);
      in_ex = (bus.state == S_EXECUTE) || (bus.state == S_MEMORY) || (bus.state == S_WRITEBACK);
      if (bus.alu_operation !== (in_ex ? v.alu : 3'b000) || bus.mux_1_sel !== (in_ex ? v.mux1 : 1'b0))
        ctrl_bad++;
      if (bus.pc_write_en) done = 1;
      @(negedge clk);
    end
    exp_count = (exp_count + 1) % 65536;
    check({tag, "_retired"}, 32'(done), 32'd1);
    check({tag, "_cycles"}, cyc, v.cycles);
    check({tag, "_im_req_cycles"}, imq, v.im_wait + 1);
    check({tag, "_dm_req_cycles"}, dmq, v.dm_cycles);
    check({tag, "_dm_we_cycles"}, dwe, v.dm_we_cycles);
    check({tag, "_ir_load"}, irl, 1);
    check({tag, "_pc_write"}, pcw, 1);
    check({tag, "_rf_write"}, rfw, v.rf);
    check({tag, "_mux2"}, m2, 32'(v.mux2));
    check({tag, "_wb_cycles"}, wbc, v.wb);
    check({tag, "_alu_ctrl_bad"}, ctrl_bad, 0);
    check({tag, "_instr_count"}, {16'd0, bus.instr_count}, exp_count);
    check({tag, "_next_state"}, {29'd0, bus.state}, v.stop ? 32'(S_IDLE) : 32'(S_FETCH));
    $display("txn %s instr=%08h cycles=%0d count=%0h", tag, v.instr, cyc, bus.instr_count);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.im_ack = 1'b0;
    bus.dm_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    exp_count = 0;
  endtask

  task automatic run_illegal(input logic [31:0] instr, input string tag);
    int cyc = 0, noisy = 0;
    begin_instr(tag);
    bus.stop = 1'b0;
    while (bus.state != S_HALT && cyc < 20) begin
      bus.instruction = instr;
      bus.im_ack = bus.im_req;
      bus.dm_ack = 1'b0;
      #1;
      cyc++;
      noisy += int'(bus.pc_write_en) + int'(bus.rf_write_en) + int'(bus.dm_req);
      @(negedge clk);
    end
    check({tag, "_cycles_to_halt"}, cyc, 2);
    check({tag, "_illegal_flag"}, 32'(bus.illegal), 32'd1);
    for (int i = 0; i < 6; i++) begin
      bus.start  = i[0];
      bus.stop   = ~i[0];
      bus.im_ack = 1'b1;
      bus.dm_ack = 1'b1;
      #1;
      noisy += int'(bus.im_req) + int'(bus.dm_req) + int'(bus.ir_load) + int'(bus.pc_write_en)
             + int'(bus.rf_write_en) + int'(bus.dm_write_en) + int'(bus.mux_1_sel)
             + int'(bus.mux_2_sel) + int'(bus.alu_operation != 3'b000);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_halt_quiet"}, noisy, 0);
    check({tag, "_halt_held"}, {29'd0, bus.state}, {29'd0, S_HALT});
    check({tag, "_count_kept"}, {16'd0, bus.instr_count}, exp_count);
    $display("txn %s instr=%08h halted illegal=%0b", tag, instr, bus.illegal);
  endtask

  initial begin
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] ins;
    int          n;

    tbl[0] = '{32'h007981B3, 0, 0, 1'b1, 4, 3'b000, 1'b0, 1'b0, 1, 1, 0, 0};
    tbl[1] = '{32'h41FC8333, 0, 0, 1'b0, 4, 3'b001, 1'b0, 1'b0, 1, 1, 0, 0};
    tbl[2] = '{32'h06B38183, 0, 2, 1'b1, 7, 3'b000, 1'b1, 1'b1, 1, 1, 3, 0};
    tbl[3] = '{32'hB679B1A3, 1, 0, 1'b1, 5, 3'b000, 1'b1, 1'b0, 0, 0, 1, 1};
    tbl[4] = '{32'h00208033, 3, 0, 1'b0, 7, 3'b000, 1'b0, 1'b0, 0, 1, 0, 0};
    tbl[5] = '{32'hB679B1A3, 2, 3, 1'b0, 9, 3'b000, 1'b1, 1'b0, 0, 0, 4, 4};
    tbl[6] = '{32'h00003003, 0, 1, 1'b1, 6, 3'b000, 1'b1, 1'b1, 0, 1, 2, 0};

    bus.instruction = 32'd0;
    do_reset();
    reset = 1'b1;
    #1;
    check("rst_state", {29'd0, bus.state}, {29'd0, S_IDLE});
    check("rst_outputs", {22'd0, bus.im_req, bus.dm_req, bus.ir_load, bus.pc_write_en, bus.rf_write_en,
                          bus.dm_write_en, bus.mux_1_sel, bus.mux_2_sel, bus.illegal, bus.alu_operation != 3'b000}, 32'd0);
    check("rst_count", {16'd0, bus.instr_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_without_start", {29'd0, bus.state}, {29'd0, S_IDLE});

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      rd  = 5'($urandom());
      rs1 = 5'($urandom());
      rs2 = 5'($urandom());
      imm = 12'($urandom());
      case ($urandom_range(0, 3))
        0: ins = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
        1: ins = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
        2: ins = {imm, rs1, 3'b011, rd, 7'b0000011};
        default: ins = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      endcase
      run_vec(model(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1))),
              $sformatf("rnd%0d", i));
    end

    // Reset while a load is stalled waiting for dm_ack.
    bus.stop = 1'b1;
    begin_instr("rstmem");
    n = 0;
    while (bus.state != S_MEMORY && n < 20) begin
      bus.instruction = 32'h06B38183;
      bus.im_ack = bus.im_req;
      bus.dm_ack = 1'b0;
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    check("rstmem_waiting", {30'd0, bus.dm_req, bus.state == S_MEMORY}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("rstmem_dm_req", 32'(bus.dm_req), 32'd0);
    check("rstmem_state", {29'd0, bus.state}, {29'd0, S_IDLE});
    check("rstmem_count", {16'd0, bus.instr_count}, 32'd0);
    check("rstmem_no_retire", 32'(bus.pc_write_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    @(negedge clk);
    @(negedge clk);
    check("rstmem_stays_idle", {29'd0, bus.state}, {29'd0, S_IDLE});
    $display("txn rstmem state=%0d count=%0h", bus.state, bus.instr_count);

    // Counter wrap: preset to FFFF, then retire one add.
    force dut.instr_count_reg = 16'hFFFF;
    #1;
    release dut.instr_count_reg;
    @(negedge clk);
    check("wrap_preset", {16'd0, bus.instr_count}, 32'h0000FFFF);
    exp_count = 16'hFFFF;
    run_vec(tbl[0], "wrap");

    run_illegal(32'h00000013, "ill0");
    do_reset();
    @(negedge clk);
    check("ill0_cleared", {31'd0, bus.illegal}, 32'd0);
    run_illegal(32'h00001033, "ill1");
    do_reset();
    run_vec(tbl[1], "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
